// File: rtl/ctl_trigger_multi.sv
// Multi-channel trigger governor: per-channel trigger debounce, photodetector
// or cursor hit detection, one-cycle shot/hit/miss/dry-fire pulses, ammunition
// tracking and a post-shot cooldown. Channels share only the reload strobe.
module ctl_trigger_multi #(
    parameter int    CHANNELS        = 2,
    parameter int    DEBOUNCE_CYCLES = 16,
    parameter int    DETECT_CYCLES   = 8,
    parameter int    COOLDOWN_CYCLES = 32,
    parameter int    AMMO_MAX        = 3,
    localparam int   AMMO_W          = $clog2(AMMO_MAX + 1)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [CHANNELS-1:0]        gun_is_connected,
    input  logic [CHANNELS-1:0]        gun_trigger,
    input  logic [CHANNELS-1:0]        gun_photodetector,
    input  logic [CHANNELS-1:0]        mouse_on_target,
    input  logic [CHANNELS-1:0]        mouse_left,
    input  logic                       reload,
    output logic [CHANNELS-1:0]        shot_fired,
    output logic [CHANNELS-1:0]        hit,
    output logic [CHANNELS-1:0]        miss,
    output logic [CHANNELS-1:0]        dry_fire,
    output logic [CHANNELS-1:0]        busy,
    output logic [CHANNELS*AMMO_W-1:0] ammo_left
);

    localparam int TMR_MAX = (DETECT_CYCLES > COOLDOWN_CYCLES) ? DETECT_CYCLES : COOLDOWN_CYCLES;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);
    localparam int DB_W    = $clog2(DEBOUNCE_CYCLES + 1);

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_DETECT   = 2'd1;
    localparam logic [1:0] ST_COOLDOWN = 2'd2;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic              raw;
        logic              mode_q;
        logic              mode_chg;
        logic              deb_q;
        logic              edge_q;
        logic [DB_W-1:0]   db_cnt_q;
        logic [1:0]        state_q;
        logic [TMR_W-1:0]  tmr_q;
        logic              gun_lat_q;
        logic              hit_flag_q;
        logic              hit_acc;
        logic              det_last;
        logic              cd_last;
        logic              fire;
        logic [AMMO_W-1:0] ammo_q;
        logic              shot_q;
        logic              hit_q;
        logic              miss_q;
        logic              dry_q;

        assign raw      = gun_is_connected[i] ? ~gun_trigger[i] : mouse_left[i];
        assign mode_chg = gun_is_connected[i] != mode_q;

        // Debounce the selected trigger; flag the cycle the level first reads 1.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                mode_q   <= 1'b0;
                deb_q    <= 1'b0;
                db_cnt_q <= '0;
                edge_q   <= 1'b0;
            end else begin
                // NOTE: sequential state uses <= so every register samples pre-edge values.
                mode_q <= gun_is_connected[i];
                edge_q <= 1'b0;
                if (mode_chg) begin
                    // Switching source adopts the new level silently: no edge.
                    deb_q    <= raw;
                    db_cnt_q <= '0;
                end else if (raw == deb_q) begin
                    db_cnt_q <= '0;
                end else if (db_cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                    deb_q    <= raw;
                    db_cnt_q <= '0;
                    edge_q   <= raw;
                end else begin
                    db_cnt_q <= db_cnt_q + DB_W'(1);
                end
            end
        end

        assign hit_acc  = hit_flag_q | (gun_lat_q & gun_photodetector[i]);
        assign det_last = ~gun_lat_q | (tmr_q == TMR_W'(DETECT_CYCLES - 1));
        assign cd_last  = tmr_q == TMR_W'(COOLDOWN_CYCLES - 1);
        assign fire     = (state_q == ST_IDLE) && edge_q && (ammo_q != '0);

        // Shot sequencer: IDLE -> DETECT -> COOLDOWN, emitting the result pulses.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                state_q    <= ST_IDLE;
                tmr_q      <= '0;
                gun_lat_q  <= 1'b0;
                hit_flag_q <= 1'b0;
                shot_q     <= 1'b0;
                hit_q      <= 1'b0;
                miss_q     <= 1'b0;
                dry_q      <= 1'b0;
            end else begin
                // NOTE: pulses default low each cycle; the case arms only raise them.
                shot_q <= 1'b0;
                hit_q  <= 1'b0;
                miss_q <= 1'b0;
                dry_q  <= 1'b0;
                case (state_q)
                    ST_IDLE: begin
                        if (fire) begin
                            shot_q     <= 1'b1;
                            gun_lat_q  <= gun_is_connected[i];
                            hit_flag_q <= ~gun_is_connected[i] & mouse_on_target[i];
                            tmr_q      <= '0;
                            state_q    <= ST_DETECT;
                        end else if (edge_q) begin
                            dry_q <= 1'b1;
                        end
                    end
                    ST_DETECT: begin
                        if (det_last) begin
                            hit_q      <= hit_acc;
                            miss_q     <= ~hit_acc;
                            hit_flag_q <= 1'b0;
                            tmr_q      <= '0;
                            state_q    <= ST_COOLDOWN;
                        end else begin
                            hit_flag_q <= hit_acc;
                            tmr_q      <= tmr_q + TMR_W'(1);
                        end
                    end
                    ST_COOLDOWN: begin
                        if (cd_last) begin
                            tmr_q   <= '0;
                            state_q <= ST_IDLE;
                        end else begin
                            tmr_q <= tmr_q + TMR_W'(1);
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end

        // Ammunition: reload wins over a same-cycle shot; shots need ammo > 0.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                ammo_q <= AMMO_W'(AMMO_MAX);
            end else if (reload) begin
                ammo_q <= AMMO_W'(AMMO_MAX);
            end else if (fire) begin
                ammo_q <= ammo_q - AMMO_W'(1);
            end
        end

        assign shot_fired[i]                  = shot_q;
        assign hit[i]                         = hit_q;
        assign miss[i]                        = miss_q;
        assign dry_fire[i]                    = dry_q;
        assign busy[i]                        = state_q != ST_IDLE;
        assign ammo_left[i*AMMO_W +: AMMO_W]  = ammo_q;
    end

endmodule
